// File: rtl/ex_result_stage.sv
// rtl/ex_result_stage.sv - EX/MEM result register with 2-entry skid buffer, condition codes and branch resolve
module ex_result_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_z,
  input  logic          alu_v,
  input  logic          alu_n,
  input  logic [RW-1:0] in_dest,
  input  logic          in_wr_en,
  input  logic          in_set_flags,
  input  logic          in_branch,
  input  logic [2:0]    in_cond,
  input  logic [DW-1:0] in_target,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_dest,
  output logic          out_wr_en,
  output logic          cc_z,
  output logic          cc_v,
  output logic          cc_n,
  output logic          br_taken,
  output logic [DW-1:0] br_target
);

  logic          head_valid, skid_valid;
  logic [DW-1:0] head_result, skid_result;
  logic [RW-1:0] head_dest, skid_dest;
  logic          head_wr_en, skid_wr_en;

  logic          n_head_valid, n_skid_valid;
  logic [DW-1:0] n_head_result, n_skid_result;
  logic [RW-1:0] n_head_dest, n_skid_dest;
  logic          n_head_wr_en, n_skid_wr_en;

  logic accept, pop, cond_true;

  assign accept     = in_valid & in_ready & ~flush;
  assign pop        = head_valid & out_ready;
  assign out_valid  = head_valid;
  assign out_result = head_result;
  assign out_dest   = head_dest;
  assign out_wr_en  = head_wr_en;

  // Evaluated against the committed flags, before any same-cycle update.
  always_comb begin
    cond_true = 1'b0;
    case (in_cond)
      3'b000:  cond_true = cc_z;
      3'b001:  cond_true = ~cc_z;
      3'b010:  cond_true = cc_n ^ cc_v;
      3'b011:  cond_true = ~(cc_n ^ cc_v);
      3'b100:  cond_true = ~cc_z & ~(cc_n ^ cc_v);
      3'b101:  cond_true = cc_z | (cc_n ^ cc_v);
      3'b110:  cond_true = 1'b1;
      default: cond_true = cc_v;
    endcase
  end

  always_comb begin
    n_head_valid  = head_valid;
    n_head_result = head_result;
    n_head_dest   = head_dest;
    n_head_wr_en  = head_wr_en;
    n_skid_valid  = skid_valid;
    n_skid_result = skid_result;
    n_skid_dest   = skid_dest;
    n_skid_wr_en  = skid_wr_en;
    if (flush) begin
      n_head_valid = 1'b0;
      n_skid_valid = 1'b0;
    end else if (!head_valid) begin
      if (accept) begin
        n_head_valid  = 1'b1;
        n_head_result = alu_result;
        n_head_dest   = in_dest;
        n_head_wr_en  = in_wr_en;
      end
    end else if (!skid_valid) begin
      if (accept && pop) begin
        n_head_result = alu_result;
        n_head_dest   = in_dest;
        n_head_wr_en  = in_wr_en;
      end else if (accept) begin
        n_skid_valid  = 1'b1;
        n_skid_result = alu_result;
        n_skid_dest   = in_dest;
        n_skid_wr_en  = in_wr_en;
      end else if (pop) begin
        n_head_valid = 1'b0;
      end
    end else if (pop) begin
      n_head_result = skid_result;
      n_head_dest   = skid_dest;
      n_head_wr_en  = skid_wr_en;
      n_skid_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid  <= 1'b0;
      head_result <= '0;
      head_dest   <= '0;
      head_wr_en  <= 1'b0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_dest   <= '0;
      skid_wr_en  <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      head_valid  <= n_head_valid;
      head_result <= n_head_result;
      head_dest   <= n_head_dest;
      head_wr_en  <= n_head_wr_en;
      skid_valid  <= n_skid_valid;
      skid_result <= n_skid_result;
      skid_dest   <= n_skid_dest;
      skid_wr_en  <= n_skid_wr_en;
      in_ready    <= ~n_skid_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_z      <= 1'b0;
      cc_v      <= 1'b0;
      cc_n      <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      br_taken <= accept & in_branch & cond_true;
      if (accept && in_branch) br_target <= in_target;
      if (accept && in_set_flags) begin
        cc_z <= alu_z;
        cc_v <= alu_v;
        cc_n <= alu_n;
      end
    end
  end

endmodule

// File: tb/tb_ex_result_stage.sv
// tb/tb_ex_result_stage.sv - scoreboard bench for ex_result_stage
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] alu_result;
  logic        alu_z, alu_v, alu_n;
  logic [2:0]  in_dest;
  logic        in_wr_en, in_set_flags, in_branch;
  logic [2:0]  in_cond;
  logic [15:0] in_target;
  logic        flush;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_dest;
  logic        out_wr_en;
  logic        cc_z, cc_v, cc_n;
  logic        br_taken;
  logic [15:0] br_target;

  ex_result_stage #(.DW(16), .RW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .in_dest(in_dest), .in_wr_en(in_wr_en), .in_set_flags(in_set_flags),
    .in_branch(in_branch), .in_cond(in_cond), .in_target(in_target),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .out_wr_en(out_wr_en),
    .cc_z(cc_z), .cc_v(cc_v), .cc_n(cc_n), .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r;
    logic [2:0]  d;
    logic        w;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic m_z = 1'b0, m_v = 1'b0, m_n = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_eval(input logic [2:0] c, input logic z, input logic v, input logic n);
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n != v;
      3'd3: return n == v;
      3'd4: return !z && (n == v);
      3'd5: return z || (n != v);
      3'd6: return 1'b1;
      default: return v;
    endcase
  endfunction

  // Every memory-stage handshake must match the oldest accepted instruction.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        ent_t e;
        e = sb.pop_front();
        check("out_result", out_result, e.r);
        check("out_dest", out_dest, e.d);
        check("out_wr_en", out_wr_en, e.w);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; alu_result = 0; alu_z = 0; alu_v = 0; alu_n = 0;
    in_dest = 0; in_wr_en = 0; in_set_flags = 0; in_branch = 0;
    in_cond = 0; in_target = 0; flush = 0;
  endtask

  task automatic send(input logic [15:0] res, input logic [2:0] dest, input logic wr,
                      input logic sf, input logic z, input logic v, input logic n,
                      input logic br, input logic [2:0] cond, input logic [15:0] tgt);
    logic done, exp_br;
    done = 0;
    in_valid = 1; alu_result = res; in_dest = dest; in_wr_en = wr;
    in_set_flags = sf; alu_z = z; alu_v = v; alu_n = n;
    in_branch = br; in_cond = cond; in_target = tgt;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) begin
        exp_br = br && cond_eval(cond, m_z, m_v, m_n);
        sb.push_back('{r: res, d: dest, w: wr});
        tick();
        done = 1;
        if (sf) begin m_z = z; m_v = v; m_n = n; end
        check("br_taken", br_taken, exp_br);
        if (br) check("br_target", br_target, tgt);
        check("cc_flags", {cc_z, cc_v, cc_n}, {m_z, m_v, m_n});
      end else tick();
    end
    if (!done) check("accept_timeout", 0, 1);
    in_valid = 0; in_set_flags = 0; in_branch = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    out_ready = 1;
    rst_n = 0;
    #23 rst_n = 1;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cc", {cc_z, cc_v, cc_n}, 0);
    check("rst_br", {br_taken, br_target}, 0);
    check("rst_out", {out_result, out_dest, out_wr_en}, 0);

    // single write, one-cycle latency
    send(16'h1234, 3'd3, 1, 0, 0, 0, 0, 0, 0, 0);
    check("w1_valid", out_valid, 1);
    check("w1_result", out_result, 16'h1234);
    check("w1_dest", out_dest, 3);
    tick();
    check("w1_drop", out_valid, 0);

    // back-pressure
    out_ready = 0;
    send(16'h0001, 3'd1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("bp_ready_a", in_ready, 1);
    send(16'h0002, 3'd2, 1, 0, 0, 0, 0, 0, 0, 0);
    check("bp_ready_b", in_ready, 0);
    in_valid = 1; alu_result = 16'h0003; in_dest = 3'd3; in_wr_en = 1;
    tick();
    tick();
    check("bp_hold_ready", in_ready, 0);
    check("bp_hold_head", out_result, 16'h0001);
    out_ready = 1;
    send(16'h0003, 3'd3, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("bp_drained", sb.size(), 0);
    check("bp_empty", out_valid, 0);

    // flags and branches
    send(16'h0000, 3'd0, 0, 1, 1, 0, 0, 0, 0, 0);
    check("cc_z_set", cc_z, 1);
    send(16'h0000, 3'd0, 0, 0, 0, 0, 0, 1, 3'b000, 16'h0040);
    check("eq_taken", br_taken, 1);
    check("eq_target", br_target, 16'h0040);
    tick();
    check("br_pulse_end", br_taken, 0);
    send(16'h0000, 3'd0, 0, 0, 0, 0, 0, 1, 3'b001, 16'h0080);
    check("ne_not_taken", br_taken, 0);

    // all conditions over several flag patterns
    for (int k = 0; k < 5; k++) begin
      logic [2:0] f;
      f = (k == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      send(16'(k), 3'd0, 0, 1, f[2], f[1], f[0], 0, 0, 0);
      for (int c = 0; c < 8; c++)
        send(16'(c), 3'(c), 0, 0, 0, 0, 0, 1, 3'(c), 16'(16'h100 + c));
    end

    // same-cycle hazard: branch sees flags from before its own update
    send(16'h0000, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0);
    send(16'h0000, 3'd0, 0, 1, 0, 0, 1, 1, 3'b010, 16'h0200);
    check("hz_taken", br_taken, 0);
    check("hz_cc_n", cc_n, 1);
    repeat (2) tick();

    // flush with full buffer
    out_ready = 0;
    send(16'h00AA, 3'd4, 1, 0, 0, 0, 0, 0, 0, 0);
    send(16'h00BB, 3'd5, 1, 0, 0, 0, 0, 0, 0, 0);
    check("fl_full", in_ready, 0);
    in_valid = 1; alu_z = 1; in_set_flags = 1; in_branch = 1; in_cond = 3'b110;
    in_target = 16'h0300; flush = 1;
    tick();
    idle_inputs();
    sb.delete();
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_cc_z", cc_z, m_z);
    check("fl_br", br_taken, 0);
    out_ready = 1;

    // asynchronous reset with two entries held and cc_n=1
    send(16'h0000, 3'd0, 0, 1, 0, 0, 1, 0, 0, 0);
    repeat (2) tick();
    out_ready = 0;
    send(16'h0011, 3'd1, 1, 0, 0, 0, 0, 0, 0, 0);
    send(16'h0022, 3'd2, 1, 0, 0, 0, 0, 0, 0, 0);
    check("ar_pre_cc_n", cc_n, 1);
    check("ar_pre_full", in_ready, 0);
    #2 rst_n = 0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_cc", {cc_z, cc_v, cc_n}, 0);
    check("ar_br", {br_taken, br_target}, 0);
    check("ar_out", {out_result, out_dest, out_wr_en}, 0);
    sb.delete();
    m_z = 0; m_v = 0; m_n = 0;
    #1 rst_n = 1;
    out_ready = 1;
    tick();
    send(16'hBEEF, 3'd7, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- EX/MEM boundary register placed directly downstream of the 16-bit ALU.
- Captures the ALU result and its z/v/n flags together with instruction sideband.
- Maintains the architectural condition-code register and resolves conditional branches against it.
- Holds data in a 2-entry skid buffer so a stall from the memory stage never drops an ALU result.

Parameters:
- DW, 16, datapath width of the result and branch target.
- RW, 3, destination register index width.

Ports:
- clk  input  1  single clock; every register is updated on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU output holds a valid instruction this cycle.
- in_ready  output  1  stage can accept an instruction; registered.
- alu_result  input  DW  ALU result.
- alu_z, alu_v, alu_n  input  1 each  ALU zero, overflow and negative flags.
- in_dest  input  RW  destination register index.
- in_wr_en  input  1  instruction writes the register file.
- in_set_flags  input  1  instruction updates the condition codes.
- in_branch  input  1  instruction is a conditional branch.
- in_cond  input  3  branch condition code.
- in_target  input  DW  branch target address.
- flush  input  1  kill every entry in flight in this stage.
- out_valid  output  1  out_* fields are valid.
- out_ready  input  1  memory stage accepts the entry.
- out_result  output  DW  result at the head of the buffer.
- out_dest  output  RW  destination register index at the head.
- out_wr_en  output  1  write enable at the head.
- cc_z, cc_v, cc_n  output  1 each  committed condition codes.
- br_taken  output  1  one-cycle pulse: the branch was taken.
- br_target  output  DW  target address, valid while br_taken is high.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Both skid entries are invalid.
  - out_valid=0, in_ready=1.
  - cc_z=cc_v=cc_n=0.
  - br_taken=0, br_target=0.
  - out_result, out_dest, out_wr_en = 0.
- Storage:
  - Two entries: head (drives out_*) and skid.
  - Each entry holds valid, result, dest and wr_en.
- Accept and handshake:
  - accept = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready.
  - Latency is 1 cycle: a value accepted at edge k appears on out_* after edge k when the head is empty, or when the head pops at that same edge.
- in_ready:
  - Registered.
  - Equals ~skid_valid as it stands after the edge.
- Occupancy transitions:
  - Empty + accept → head filled.
  - Head only, accept with no pop → entry goes to skid; in_ready falls the next cycle.
  - Head only, accept and pop together → head is replaced; stays 1 entry.
  - Full + pop → skid moves to head; in_ready rises.
  - Full + in_valid → no accept (in_ready=0), so no overflow is possible.
  - Order is strictly FIFO; no entry is duplicated or lost.
- Flush:
  - Synchronous. At the edge, both entries become invalid and no input is accepted.
  - Condition codes are not updated and br_taken is forced 0 for that cycle's input.
  - Flush has priority over pop and accept.
  - in_ready=1 the following cycle.
- Condition codes:
  - On accept with in_set_flags=1, cc_* <= alu_z, alu_v, alu_n.
  - They change only on accept; a stall or pop alone does not update them.
- Branch resolution:
  - On accept with in_branch=1, br_taken <= cond_true for one cycle, and br_target <= in_target.
  - cond_true is evaluated against the cc_* values BEFORE the update in that same cycle. If the branch also has in_set_flags=1, the branch still uses the old flags.
  - br_taken is 0 on every cycle without a branch accept.
- Branch conditions (in_cond):
  - 000 EQ: z
  - 001 NE: ~z
  - 010 LT: n^v
  - 011 GE: ~(n^v)
  - 100 GT: ~z & ~(n^v)
  - 101 LE: z | (n^v)
  - 110 AL: 1
  - 111 VS: v
- Branches in the buffer: a branch with in_wr_en=0 still occupies a buffer entry and pops normally.
- Mid-operation reset: asserting rst_n=0 at any time clears all state immediately, independent of clk.

Test Plan:
- Reset, then a single write: drive alu_result=16'h1234, dest=3, wr_en=1, with out_ready=1. out_valid rises one cycle later with out_result=16'h1234 and out_dest=3; it drops the next cycle when in_valid=0.
- Back-pressure: hold out_ready=0 and stream A=16'h0001, B=16'h0002, C=16'h0003. in_ready falls after B and C is held off. Then release out_ready=1: the outputs appear in order 1, 2, 3 with no loss and no duplicates.
- Flags and branches:
  - Instruction with set_flags=1, z=1 → cc_z=1.
  - Next, a branch with cond=000 and target=16'h0040 → br_taken pulse, br_target=16'h0040.
  - Then a branch with cond=001 → br_taken stays 0.
- Same-cycle hazard: cc_n=0, cc_v=0, then a branch with cond=010 and set_flags=1, alu_n=1 → br_taken=0 (old flags used), and cc_n=1 afterwards.
- Flush with a full buffer and in_valid=1, alu_z=1, set_flags=1, branch cond=110:
  - out_valid=0 next cycle, in_ready=1.
  - cc_z is unchanged and br_taken=0.
- Asynchronous reset: with 2 entries held and cc_n=1, pulse rst_n low between clock edges. All outputs return to reset values at once, and in_ready=1.
